pipe_rate_change_ctrl: RTL and testbench
========================================

Name: pipe_rate_change_ctrl

Overview:
Sequences the PIPE rate/PCLK-rate change handshake between the LTSSM and the PHY; this handshake is currently left undriven at the PCIe top. It accepts a target-generation request and forces TxElecIdle on all lanes. It then drives Rate, PCLKRate and width, and runs the PclkChangeOk / PclkChangeAck / PhyStatus handshake across the active lanes. It reports done or error back to the LTSSM.

Parameters:
LANESNUMBER, 16, number of PIPE lanes
MAX_GEN, 1, highest generation accepted (1..5)
GEN1_PIPEWIDTH..GEN5_PIPEWIDTH, 8, PIPE data width per generation (8/16/32)
EIDLE_CYCLES, 8, pclk cycles TxElecIdle is held before Rate changes (>=1)
TIMEOUT_CYCLES, 4096, cycle budget per wait state before error

Ports:
pclk  in  1  PIPE clock
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  rate-change request strobe from LTSSM
req_gen  in  3  target generation, 1..5
req_ready  out  1  high only in IDLE
lane_mask  in  LANESNUMBER  active lanes, sampled on request accept
done  out  1  one-cycle pulse: change complete
error  out  1  one-cycle pulse: rejected or timed out
cur_gen  out  3  generation currently in force
Rate  out  4  PIPE Rate
PCLKRate  out  5  PIPE PCLKRate
width  out  2  PIPE width code: 8->0, 16->1, 32->2
PclkChangeAck  out  1  MAC ack to PHY
PclkChangeOk  in  1  PHY ready for PCLK change
PhyStatus  in  LANESNUMBER  per-lane PHY completion
TxElecIdle  out  LANESNUMBER  forced electrical idle during change

Behaviour:
- Reset values: cur_gen=1, Rate=0, PCLKRate=0, width=code(GEN1_PIPEWIDTH), TxElecIdle=0, PclkChangeAck=0, done=0, error=0, req_ready=1, state IDLE, counters 0.
- Encoding: Rate=PCLKRate=gen-1, zero-extended. width is always code(GENx_PIPEWIDTH) of cur_gen, registered.
- Request handshake: accepted when req_valid && req_ready. req_gen and lane_mask are latched. The previous gen is saved.
- Accept-cycle decisions:
  - req_gen==0 or req_gen>MAX_GEN: error pulse next cycle, no output change, stay IDLE.
  - req_gen==cur_gen: done pulse next cycle, no handshake.
  - lane_mask==0: treated as the all-ones mask.
- States:
  - IDLE: TxElecIdle=0. On a valid new gen -> EIDLE.
  - EIDLE: TxElecIdle=all ones, count EIDLE_CYCLES -> SET_RATE.
  - SET_RATE (1 cycle): Rate, PCLKRate and cur_gen updated to target -> WAIT_OK.
  - WAIT_OK: wait for PclkChangeOk==1 -> ACK, asserting PclkChangeAck on the transition edge.
  - ACK: PclkChangeAck=1. Per-lane sticky register collects PhyStatus&mask; PhyStatus may arrive on different cycles per lane. When sticky==mask -> RELEASE.
  - RELEASE (1 cycle): PclkChangeAck=0, TxElecIdle=0, done pulse -> IDLE.
- Width update: width changes in the same cycle Rate changes.
- Timeout: one counter, cleared on every state entry, active in WAIT_OK and ACK.
  - Reaching TIMEOUT_CYCLES-1 without exit restores previous gen on Rate, PCLKRate, cur_gen and width.
  - It also drops PclkChangeAck, releases TxElecIdle, pulses error and returns to IDLE.
- PhyStatus outside ACK is ignored; it does not pre-load the sticky register.
- PclkChangeOk deasserting during ACK is ignored.
- req_valid while not IDLE is ignored (req_ready=0); no queuing.
- done and error are never asserted together.
- Async reset mid-sequence returns to the reset values immediately, including PclkChangeAck=0.

Decomposition:
- Shared package pcie_pipe_pkg:
  - state enum for this block
  - gen_to_rate and gen_to_pclkrate functions
  - pipewidth_to_code function
  - GEN1..GEN5 localparams
- Sub-module: none required. The per-lane PhyStatus sticky collector may be written as pipe_phystatus_collect (LANESNUMBER-wide, clear/enable/all_done) for reuse by the powerdown controller.

Test Plan:
- Reset: assert reset_n=0 mid-ACK -> PclkChangeAck=0, Rate=0, cur_gen=1, TxElecIdle=0 within the same cycle.
- MAX_GEN=3, req_gen=2, mask=16'hFFFF:
  - TxElecIdle=FFFF for 8 cycles, then Rate=1, PCLKRate=1.
  - PclkChangeOk=1 -> Ack=1.
  - PhyStatus pulsed lanes 0-7 at t, lanes 8-15 at t+3 -> done on cycle after t+3, Ack=0.
- Staggered mask: mask=16'h000F, PhyStatus only on lanes 0-3 -> done. PhyStatus on lanes 4-15 alone -> no done.
- Reject:
  - req_gen=4 with MAX_GEN=3 -> error one cycle later, Rate unchanged.
  - req_gen=cur_gen -> done one cycle later, TxElecIdle never asserted.
- Timeout: TIMEOUT_CYCLES=16, PclkChangeOk never asserted -> error 16 cycles after WAIT_OK entry, Rate back to previous value, req_ready=1.
- Width: GEN2_PIPEWIDTH=16, change 1->2 -> width goes 0->1 in the SET_RATE cycle.

Source files
------------

// File: rtl/pcie_pipe_pkg.sv
// Shared PIPE definitions: generation constants, rate-change FSM states and
// helpers that map a generation / PIPE data width onto PIPE encodings.
package pcie_pipe_pkg;

  localparam logic [2:0] GEN1 = 3'd1;
  localparam logic [2:0] GEN2 = 3'd2;
  localparam logic [2:0] GEN3 = 3'd3;
  localparam logic [2:0] GEN4 = 3'd4;
  localparam logic [2:0] GEN5 = 3'd5;

  typedef enum logic [2:0] {
    RC_IDLE     = 3'd0,
    RC_EIDLE    = 3'd1,
    RC_SET_RATE = 3'd2,
    RC_WAIT_OK  = 3'd3,
    RC_ACK      = 3'd4,
    RC_RELEASE  = 3'd5
  } rateChgState_t;

  // Rate is gen-1, zero-extended; callers only pass a valid generation.
  function automatic logic [3:0] gen_to_rate(input logic [2:0] gen);
    return 4'(gen - 3'd1);
  endfunction

  function automatic logic [4:0] gen_to_pclkrate(input logic [2:0] gen);
    return 5'(gen - 3'd1);
  endfunction

  // PIPE width code: 8 -> 0, 16 -> 1, 32 -> 2.
  function automatic logic [1:0] pipewidth_to_code(input int unsigned w);
    case (w)
      16:      return 2'd1;
      32:      return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_phystatus_collect.sv
// Per-lane sticky collector for PhyStatus completions.
//   pclk, reset_n : clock, async active-low reset
//   clear         : drop all collected lanes
//   enable        : collect PhyStatus & mask this cycle
//   mask          : lanes that must complete
//   phyStatus     : per-lane PHY completion pulses
//   allDone_c     : every masked lane has completed, including this cycle
module pipe_phystatus_collect #(
  parameter int unsigned LANESNUMBER = 16
) (
  input  logic                   pclk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   enable,
  input  logic [LANESNUMBER-1:0] mask,
  input  logic [LANESNUMBER-1:0] phyStatus,
  output logic                   allDone_c
);

  logic [LANESNUMBER-1:0] sticky;
  logic [LANESNUMBER-1:0] seenNow;

  // Lanes seen so far plus this cycle's completions, so a lane finishing
  // on the last cycle is recognised without an extra cycle of latency.
  assign seenNow   = sticky | (phyStatus & mask & {LANESNUMBER{enable}});
  assign allDone_c = enable && (seenNow == mask);

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      sticky <= '0;
    end else if (clear) begin
      sticky <= '0;
    end else if (enable) begin
      sticky <= seenNow;
    end
  end

endmodule

// File: rtl/pipe_rate_change_ctrl.sv
// PIPE rate / PCLK-rate change sequencer between the LTSSM and the PHY.
//   LTSSM side : req_valid/req_gen/lane_mask in, req_ready/done/error/cur_gen out
//   PHY side   : Rate, PCLKRate, width, PclkChangeAck, TxElecIdle out;
//                PclkChangeOk, PhyStatus in
module pipe_rate_change_ctrl
  import pcie_pipe_pkg::*;
#(
  parameter int unsigned LANESNUMBER    = 16,
  parameter int unsigned MAX_GEN        = 1,
  parameter int unsigned GEN1_PIPEWIDTH = 8,
  parameter int unsigned GEN2_PIPEWIDTH = 8,
  parameter int unsigned GEN3_PIPEWIDTH = 8,
  parameter int unsigned GEN4_PIPEWIDTH = 8,
  parameter int unsigned GEN5_PIPEWIDTH = 8,
  parameter int unsigned EIDLE_CYCLES   = 8,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                   pclk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  input  logic [2:0]             req_gen,
  output logic                   req_ready,
  input  logic [LANESNUMBER-1:0] lane_mask,
  output logic                   done,
  output logic                   error,
  output logic [2:0]             cur_gen,
  output logic [3:0]             Rate,
  output logic [4:0]             PCLKRate,
  output logic [1:0]             width,
  output logic                   PclkChangeAck,
  input  logic                   PclkChangeOk,
  input  logic [LANESNUMBER-1:0] PhyStatus,
  output logic [LANESNUMBER-1:0] TxElecIdle
);

  localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > EIDLE_CYCLES) ? TIMEOUT_CYCLES : EIDLE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] EIDLE_LAST   = CNT_W'(EIDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]       MAX_GEN_C    = 3'(MAX_GEN);

  function automatic logic [1:0] genWidthCode(input logic [2:0] gen);
    case (gen)
      GEN2:    return pipewidth_to_code(GEN2_PIPEWIDTH);
      GEN3:    return pipewidth_to_code(GEN3_PIPEWIDTH);
      GEN4:    return pipewidth_to_code(GEN4_PIPEWIDTH);
      GEN5:    return pipewidth_to_code(GEN5_PIPEWIDTH);
      default: return pipewidth_to_code(GEN1_PIPEWIDTH);
    endcase
  endfunction

  rateChgState_t          state;
  logic [CNT_W-1:0]       cnt;
  logic [2:0]             tgtGen;
  logic [2:0]             prevGen;
  logic [LANESNUMBER-1:0] laneMask;
  logic                   allDone_c;
  logic                   timeoutHit;

  // Sticky register only lives inside ACK; anything seen earlier is dropped.
  pipe_phystatus_collect #(
    .LANESNUMBER(LANESNUMBER)
  ) u_collect (
    .pclk      (pclk),
    .reset_n   (reset_n),
    .clear     (state != RC_ACK),
    .enable    (state == RC_ACK),
    .mask      (laneMask),
    .phyStatus (PhyStatus),
    .allDone_c (allDone_c)
  );

  assign timeoutHit = (cnt == TIMEOUT_LAST);

  // Sequencer: all outputs registered; cnt restarts at every state entry.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RC_IDLE;
      cnt           <= '0;
      tgtGen        <= GEN1;
      prevGen       <= GEN1;
      laneMask      <= '0;
      req_ready     <= 1'b1;
      done          <= 1'b0;
      error         <= 1'b0;
      cur_gen       <= GEN1;
      Rate          <= '0;
      PCLKRate      <= '0;
      width         <= pipewidth_to_code(GEN1_PIPEWIDTH);
      PclkChangeAck <= 1'b0;
      TxElecIdle    <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        RC_IDLE: begin
          if (req_valid && req_ready) begin
            if (req_gen == 3'd0 || req_gen > MAX_GEN_C) begin
              error <= 1'b1;
            end else if (req_gen == cur_gen) begin
              done <= 1'b1;
            end else begin
              tgtGen     <= req_gen;
              prevGen    <= cur_gen;
              // An empty mask means every lane takes part.
              laneMask   <= (lane_mask == '0) ? '1 : lane_mask;
              TxElecIdle <= '1;
              req_ready  <= 1'b0;
              cnt        <= '0;
              state      <= RC_EIDLE;
            end
          end
        end
        RC_EIDLE: begin
          if (cnt == EIDLE_LAST) begin
            Rate     <= gen_to_rate(tgtGen);
            PCLKRate <= gen_to_pclkrate(tgtGen);
            cur_gen  <= tgtGen;
            width    <= genWidthCode(tgtGen);
            cnt      <= '0;
            state    <= RC_SET_RATE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RC_SET_RATE: begin
          cnt   <= '0;
          state <= RC_WAIT_OK;
        end
        RC_WAIT_OK: begin
          if (PclkChangeOk) begin
            PclkChangeAck <= 1'b1;
            cnt           <= '0;
            state         <= RC_ACK;
          end else if (timeoutHit) begin
            Rate          <= gen_to_rate(prevGen);
            PCLKRate      <= gen_to_pclkrate(prevGen);
            cur_gen       <= prevGen;
            width         <= genWidthCode(prevGen);
            PclkChangeAck <= 1'b0;
            TxElecIdle    <= '0;
            error         <= 1'b1;
            req_ready     <= 1'b1;
            cnt           <= '0;
            state         <= RC_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RC_ACK: begin
          if (allDone_c) begin
            PclkChangeAck <= 1'b0;
            TxElecIdle    <= '0;
            done          <= 1'b1;
            cnt           <= '0;
            state         <= RC_RELEASE;
          end else if (timeoutHit) begin
            Rate          <= gen_to_rate(prevGen);
            PCLKRate      <= gen_to_pclkrate(prevGen);
            cur_gen       <= prevGen;
            width         <= genWidthCode(prevGen);
            PclkChangeAck <= 1'b0;
            TxElecIdle    <= '0;
            error         <= 1'b1;
            req_ready     <= 1'b1;
            cnt           <= '0;
            state         <= RC_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RC_RELEASE: begin
          req_ready <= 1'b1;
          cnt       <= '0;
          state     <= RC_IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          cnt       <= '0;
          state     <= RC_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_rate_change_ctrl.sv
// Randomised scoreboard bench for pipe_rate_change_ctrl (MAX_GEN=3,
// 8/16/32-bit widths for gen1/2/3, EIDLE_CYCLES=8, TIMEOUT_CYCLES=16).
module tb_pipe_rate_change_ctrl;

  localparam int LN   = 16;
  localparam int MAXG = 3;
  localparam int EC   = 8;
  localparam int TC   = 16;

  logic          pclk;
  logic          reset_n;
  logic          req_valid;
  logic [2:0]    req_gen;
  logic          req_ready;
  logic [LN-1:0] lane_mask;
  logic          done;
  logic          error;
  logic [2:0]    cur_gen;
  logic [3:0]    Rate;
  logic [4:0]    PCLKRate;
  logic [1:0]    width;
  logic          PclkChangeAck;
  logic          PclkChangeOk;
  logic [LN-1:0] PhyStatus;
  logic [LN-1:0] TxElecIdle;

  pipe_rate_change_ctrl #(
    .LANESNUMBER(LN), .MAX_GEN(MAXG),
    .GEN1_PIPEWIDTH(8), .GEN2_PIPEWIDTH(16), .GEN3_PIPEWIDTH(32),
    .GEN4_PIPEWIDTH(8), .GEN5_PIPEWIDTH(8),
    .EIDLE_CYCLES(EC), .TIMEOUT_CYCLES(TC)
  ) dut (
    .pclk(pclk), .reset_n(reset_n), .req_valid(req_valid), .req_gen(req_gen),
    .req_ready(req_ready), .lane_mask(lane_mask), .done(done), .error(error),
    .cur_gen(cur_gen), .Rate(Rate), .PCLKRate(PCLKRate), .width(width),
    .PclkChangeAck(PclkChangeAck), .PclkChangeOk(PclkChangeOk),
    .PhyStatus(PhyStatus), .TxElecIdle(TxElecIdle)
  );

  typedef struct {
    int at;
    bit isErr;
    int gen;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   mGen   = 1;
  int   off[LN];

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc++;

  // Model PIPE width code from the bench's own width table.
  function automatic int wcode(input int g);
    int pw;
    case (g)
      2:       pw = 16;
      3:       pw = 32;
      default: pw = 8;
    endcase
    return (pw == 8) ? 0 : (pw == 16) ? 1 : 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done/error pulse must match the head of the scoreboard.
  always @(negedge pclk) begin : monitor
    exp_t e;
    if (reset_n && (done === 1'b1 || error === 1'b1)) begin
      chk("done_error_exclusive", 32'(done & error), 32'd0);
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: done=%0b error=%0b at cycle %0d, none expected", done, error, cyc);
      end else begin
        e = sbq.pop_front();
        chk("event_cycle", 32'(cyc), 32'(e.at));
        chk("event_error", 32'(error), 32'(e.isErr));
        chk("event_done", 32'(done), 32'(!e.isErr));
        chk("ev_cur_gen", 32'(cur_gen), 32'(e.gen));
        chk("ev_Rate", 32'(Rate), 32'(e.gen - 1));
        chk("ev_PCLKRate", 32'(PCLKRate), 32'(e.gen - 1));
        chk("ev_width", 32'(width), 32'(wcode(e.gen)));
        chk("ev_ack_low", 32'(PclkChangeAck), 32'd0);
        chk("ev_txei_low", 32'(TxElecIdle), 32'd0);
      end
    end
  end

  // One request; expected outcome/cycle derived from the timing rules:
  // EIDLE occupies accept+0..EC-1, SET_RATE at EC, WAIT_OK entered at EC+1.
  task automatic runTx(input int gen, input logic [LN-1:0] mask, input int okDelay,
                       input bit starve, input bit abort);
    int a, kr, maxOff, relEnd, evAt, newGen, okRel;
    bit isErr, hs, stop;
    logic [LN-1:0] eff, ps;
    eff    = (mask == '0) ? '1 : mask;
    okRel  = EC + 1 + okDelay;
    kr     = okRel + 1;
    hs     = 1'b0;
    stop   = 1'b0;
    @(negedge pclk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_gen   = 3'(gen);
    lane_mask = mask;
    a = cyc + 1;
    if (gen == 0 || gen > MAXG) begin
      isErr = 1'b1; evAt = a; newGen = mGen; relEnd = 3;
    end else if (gen == mGen) begin
      isErr = 1'b0; evAt = a; newGen = mGen; relEnd = 3;
    end else begin
      hs = 1'b1;
      maxOff = 0;
      for (int i = 0; i < LN; i++) if (eff[i] && off[i] > maxOff) maxOff = off[i];
      if (okDelay > TC - 1) begin
        isErr = 1'b1; evAt = a + EC + 1 + TC; newGen = mGen;
      end else if (starve || maxOff > TC - 1) begin
        isErr = 1'b1; evAt = a + kr + TC; newGen = mGen;
      end else begin
        isErr = 1'b0; evAt = a + kr + maxOff + 1; newGen = gen;
      end
      relEnd = evAt - a + 2;
    end
    if (!abort) sbq.push_back('{evAt, isErr, newGen});
    @(negedge pclk);
    req_valid = 1'b0;
    for (int rel = 0; rel < relEnd && !stop; rel++) begin
      if (!hs) begin
        chk("reject_txei_idle", 32'(TxElecIdle), 32'd0);
        chk("reject_rate_kept", 32'(Rate), 32'(mGen - 1));
      end else begin
        if (rel == okRel)     PclkChangeOk = 1'b1;
        else if (rel > okRel) PclkChangeOk = 1'($urandom_range(0, 1));
        else                  PclkChangeOk = 1'b0;
        for (int i = 0; i < LN; i++) begin
          if (eff[i] && rel >= kr) ps[i] = !starve && (rel == kr + off[i]);
          else                     ps[i] = 1'($urandom_range(0, 1));
        end
        PhyStatus = ps;
        if (rel < EC) begin
          chk("txei_hold", 32'(TxElecIdle), 32'hFFFF);
          chk("rate_old", 32'(Rate), 32'(mGen - 1));
          chk("width_old", 32'(width), 32'(wcode(mGen)));
        end
        if (rel == EC) begin
          chk("rate_new", 32'(Rate), 32'(gen - 1));
          chk("pclkrate_new", 32'(PCLKRate), 32'(gen - 1));
          chk("width_new", 32'(width), 32'(wcode(gen)));
          chk("cur_gen_new", 32'(cur_gen), 32'(gen));
          chk("txei_set_rate", 32'(TxElecIdle), 32'hFFFF);
        end
        if (rel == EC + 1) chk("ack_low_wait_ok", 32'(PclkChangeAck), 32'd0);
        if (rel == kr && okDelay < TC) chk("ack_high", 32'(PclkChangeAck), 32'd1);
        if (rel < evAt - a) chk("req_ready_busy", 32'(req_ready), 32'd0);
        if (rel == evAt - a + 1) chk("req_ready_back", 32'(req_ready), 32'd1);
        if (abort && rel == kr + 2) begin
          reset_n = 1'b0;
          #1;
          chk("rst_ack", 32'(PclkChangeAck), 32'd0);
          chk("rst_rate", 32'(Rate), 32'd0);
          chk("rst_pclkrate", 32'(PCLKRate), 32'd0);
          chk("rst_cur_gen", 32'(cur_gen), 32'd1);
          chk("rst_txei", 32'(TxElecIdle), 32'd0);
          chk("rst_width", 32'(width), 32'd0);
          chk("rst_req_ready", 32'(req_ready), 32'd1);
          mGen = 1;
          stop = 1'b1;
        end
      end
      @(negedge pclk);
    end
    PclkChangeOk = 1'b0;
    PhyStatus    = '0;
    if (abort) begin
      repeat (2) @(negedge pclk);
      reset_n = 1'b1;
    end else if (!isErr) begin
      mGen = newGen;
    end
  endtask

  task automatic setOff(input int lo, input int hi);
    for (int i = 0; i < LN; i++) off[i] = (i < 8) ? lo : hi;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int g, okd;
    logic [LN-1:0] m;
    reset_n = 1'b0; req_valid = 1'b0; req_gen = '0; lane_mask = '0;
    PclkChangeOk = 1'b0; PhyStatus = '0;
    setOff(0, 0);
    repeat (3) @(negedge pclk);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_cur_gen", 32'(cur_gen), 32'd1);
    chk("reset_rate", 32'(Rate), 32'd0);
    chk("reset_pclkrate", 32'(PCLKRate), 32'd0);
    chk("reset_width", 32'(width), 32'd0);
    chk("reset_ack", 32'(PclkChangeAck), 32'd0);
    chk("reset_txei", 32'(TxElecIdle), 32'd0);
    chk("reset_done_error", 32'({done, error}), 32'd0);
    reset_n = 1'b1;

    // gen1 -> gen2, lanes 0-7 complete at t, lanes 8-15 at t+3.
    setOff(2, 5);
    runTx(2, 16'hFFFF, 3, 1'b0, 1'b0);
    runTx(4, 16'hFFFF, 0, 1'b0, 1'b0);
    runTx(0, 16'hFFFF, 0, 1'b0, 1'b0);
    runTx(2, 16'hFFFF, 0, 1'b0, 1'b0);
    // Narrow mask: only lanes 0-3 matter.
    for (int i = 0; i < LN; i++) off[i] = (i < 4) ? int'($urandom_range(0, 6)) : 40;
    runTx(3, 16'h000F, 1, 1'b0, 1'b0);
    // Only unmasked lanes report: must time out in ACK.
    runTx(1, 16'h000F, 0, 1'b1, 1'b0);
    // PclkChangeOk never arrives: WAIT_OK timeout.
    runTx(1, 16'hFFFF, 20, 1'b0, 1'b0);
    // Last-cycle boundaries for both waits.
    setOff(15, 15);
    runTx(1, 16'hFFFF, 15, 1'b0, 1'b0);
    // Empty mask behaves as all lanes.
    for (int i = 0; i < LN; i++) off[i] = int'($urandom_range(0, 10));
    runTx(2, 16'h0000, 2, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      g   = int'($urandom_range(0, 5));
      okd = ($urandom_range(0, 7) == 0) ? 17 : int'($urandom_range(0, 12));
      case ($urandom_range(0, 2))
        0:       m = '0;
        1:       m = '1;
        default: m = 16'($urandom);
      endcase
      for (int i = 0; i < LN; i++)
        off[i] = ($urandom_range(0, 63) == 0) ? 16 : int'($urandom_range(0, 12));
      runTx(g, m, okd, ($urandom_range(0, 9) == 0), 1'b0);
    end

    // Async reset while in ACK, then recover.
    setOff(3, 3);
    runTx((mGen == 1) ? 2 : 1, 16'hFFFF, 2, 1'b1, 1'b1);
    runTx(3, 16'hFFFF, 0, 1'b0, 1'b0);

    repeat (4) @(negedge pclk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
